// File: rtl/fb_line_fetcher_pkg.sv
// ---------------------------------------------------------------------------
// fb_line_fetcher_pkg
// Shared constants for the framebuffer line fetcher: display geometry,
// address width, FSM state encoding and the line-offset helper.
// ---------------------------------------------------------------------------
package fb_line_fetcher_pkg;

    localparam int unsigned ADDR_W          = 13;
    localparam int unsigned DATA_W          = 16;
    localparam int unsigned FB_LINE_WORDS   = 20;
    localparam int unsigned FB_ACTIVE_LINES = 288;

    // Columns are 10-bit display-controller counts.
    localparam logic [9:0]  H_ACTIVE        = 10'd320;
    localparam logic [9:0]  X_SWAP          = 10'd1023;

    // Fetch FSM encoding (kept as plain constants for legacy compatibility).
    localparam logic [1:0]  ST_IDLE         = 2'd0;
    localparam logic [1:0]  ST_REQ          = 2'd1;
    localparam logic [1:0]  ST_DONE         = 2'd2;

    // y * mult as a sum of shifted copies of y, selected by the bits of the
    // constant multiplier; result wraps modulo 2^ADDR_W.
    function automatic logic [ADDR_W-1:0] line_offset(input logic [9:0] y,
                                                      input int unsigned mult);
        logic [ADDR_W-1:0] acc;
        acc = '0;
        for (int unsigned i = 0; i < ADDR_W; i++) begin
            if (mult[i]) begin
                acc = acc + (ADDR_W'(y) << i);
            end
        end
        return acc;
    endfunction

endpackage

// File: rtl/fb_line_fetcher_if.sv
// ---------------------------------------------------------------------------
// fb_line_fetcher_if
// Framebuffer memory read channel.
//   mem_rd_req  : read request (fetcher -> memory)
//   mem_rd_addr : 13-bit word address, stable while mem_rd_req is high
//   mem_rd_ack  : one-cycle acknowledge, data valid in the same cycle
//   mem_rd_data : 16-bit read word
// ---------------------------------------------------------------------------
interface fb_line_fetcher_if;
    import fb_line_fetcher_pkg::*;

    logic              mem_rd_req;
    logic [ADDR_W-1:0] mem_rd_addr;
    logic              mem_rd_ack;
    logic [DATA_W-1:0] mem_rd_data;

    modport master (
        output mem_rd_req,
        output mem_rd_addr,
        input  mem_rd_ack,
        input  mem_rd_data
    );

    modport slave (
        input  mem_rd_req,
        input  mem_rd_addr,
        output mem_rd_ack,
        output mem_rd_data
    );

endinterface

// File: rtl/fb_line_fetcher_bank.sv
// ---------------------------------------------------------------------------
// fb_line_bank
// One line buffer of WORDS x 16 bits: one synchronous write port and one
// asynchronous read port. Contents are not reset so the array can map to RAM.
//   clk_core_12288 : write clock
//   we/waddr/wdata : write port
//   raddr/rdata    : combinational read port (reads 0 beyond WORDS)
// ---------------------------------------------------------------------------
module fb_line_bank #(
    parameter int unsigned WORDS = 20,
    parameter int unsigned AW    = 5
) (
    input  logic          clk_core_12288,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [15:0]   wdata,
    input  logic [AW-1:0] raddr,
    output logic [15:0]   rdata
);

    logic [15:0] mem [WORDS];

    always_ff @(posedge clk_core_12288) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = (32'(raddr) < WORDS) ? mem[raddr] : '0;

endmodule

// File: rtl/fb_line_fetcher.sv
// ---------------------------------------------------------------------------
// fb_line_fetcher
// Double-buffered 1 bpp line fetcher. While one bank is displayed, the next
// line is read from framebuffer memory into the other bank; the banks swap
// one cycle before column 0.
//   clk_core_12288 : pixel clock, rising edge
//   reset_n        : asynchronous active-low reset
//   visible_x/y    : display-controller column/row (10-bit, wrapping)
//   pixel_state    : combinational pixel bit for (visible_x, visible_y)
//   underrun       : sticky, a line fetch missed its swap deadline
//   mem            : framebuffer read channel (master side)
// ---------------------------------------------------------------------------
module fb_line_fetcher
    import fb_line_fetcher_pkg::*;
#(
    parameter logic [ADDR_W-1:0] FB_BASE      = 13'd0,
    parameter int unsigned       LINE_WORDS   = FB_LINE_WORDS,
    parameter int unsigned       ACTIVE_LINES = FB_ACTIVE_LINES
) (
    input  logic                clk_core_12288,
    input  logic                reset_n,
    input  logic [9:0]          visible_x,
    input  logic [9:0]          visible_y,
    output logic                pixel_state,
    output logic                underrun,
    fb_line_fetcher_if.master   mem
);

    localparam int unsigned         WORD_W    = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1;
    localparam logic [WORD_W-1:0]   LAST_WORD = WORD_W'(LINE_WORDS - 1);
    localparam logic [9:0]          Y_LIMIT   = 10'(ACTIVE_LINES);

    logic [1:0]        state;
    logic [ADDR_W-1:0] line_base;
    logic [WORD_W-1:0] word;
    logic              disp_bank;
    logic              abort;

    logic              trigger;
    logic              deadline;
    logic [9:0]        next_y;
    logic              last_ack;
    logic              wr_en;

    assign trigger  = (visible_x == H_ACTIVE);
    assign deadline = (visible_x == X_SWAP);
    assign next_y   = visible_y + 10'd1;
    assign last_ack = (state == ST_REQ) && mem.mem_rd_ack && (word == LAST_WORD);

    // Once the deadline has passed the line is abandoned: acks are still
    // consumed to finish the bus transaction but nothing is written.
    assign wr_en    = (state == ST_REQ) && mem.mem_rd_ack && !abort && !deadline;

    // Request is decoded from state so an asynchronous reset drops it at once.
    assign mem.mem_rd_req  = (state == ST_REQ);
    assign mem.mem_rd_addr = line_base + ADDR_W'(word);

    always_ff @(posedge clk_core_12288 or negedge reset_n) begin
        if (!reset_n) begin
            state     <= ST_IDLE;
            line_base <= '0;
            word      <= '0;
            disp_bank <= 1'b0;
            abort     <= 1'b0;
            underrun  <= 1'b0;
        end else begin
            if (trigger && (state != ST_IDLE)) begin
                underrun <= 1'b1;
            end
            case (state)
                ST_IDLE: begin
                    if (trigger && (next_y < Y_LIMIT)) begin
                        line_base <= FB_BASE + line_offset(next_y, LINE_WORDS);
                        word      <= '0;
                        state     <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (deadline) begin
                        underrun <= 1'b1;
                        abort    <= 1'b1;
                    end
                    if (mem.mem_rd_ack) begin
                        if (last_ack) begin
                            // The final ack also closes out an abandoned line;
                            // this assignment overrides the abort set above.
                            state <= (abort || deadline) ? ST_IDLE : ST_DONE;
                            abort <= 1'b0;
                        end else begin
                            word <= word + WORD_W'(1);
                        end
                    end
                end
                ST_DONE: begin
                    if (deadline) begin
                        disp_bank <= ~disp_bank;
                        state     <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    logic [WORD_W-1:0] rd_word;
    logic [15:0]       row0;
    logic [15:0]       row1;
    logic [15:0]       disp_row;

    assign rd_word = WORD_W'(visible_x[8:4]);

    fb_line_bank #(.WORDS(LINE_WORDS), .AW(WORD_W)) u_bank0 (
        .clk_core_12288 (clk_core_12288),
        .we             (wr_en && disp_bank),
        .waddr          (word),
        .wdata          (mem.mem_rd_data),
        .raddr          (rd_word),
        .rdata          (row0)
    );

    fb_line_bank #(.WORDS(LINE_WORDS), .AW(WORD_W)) u_bank1 (
        .clk_core_12288 (clk_core_12288),
        .we             (wr_en && !disp_bank),
        .waddr          (word),
        .wdata          (mem.mem_rd_data),
        .raddr          (rd_word),
        .rdata          (row1)
    );

    assign disp_row = disp_bank ? row1 : row0;

    always_comb begin
        pixel_state = 1'b0;
        if ((visible_x < H_ACTIVE) && (visible_y < Y_LIMIT)) begin
            pixel_state = disp_row[visible_x[3:0]];
        end
    end

endmodule

// File: tb/tb_fb_line_fetcher.sv
module tb_fb_line_fetcher;
    import fb_line_fetcher_pkg::*;

    logic       clk_core_12288 = 1'b0;
    logic       reset_n = 1'b0;
    logic [9:0] visible_x = 10'd500;
    logic [9:0] visible_y = 10'd300;
    logic       pixel_state;
    logic       underrun;

    fb_line_fetcher_if mem_bus();

    fb_line_fetcher #(
        .FB_BASE      (13'd0),
        .LINE_WORDS   (20),
        .ACTIVE_LINES (288)
    ) dut (
        .clk_core_12288 (clk_core_12288),
        .reset_n        (reset_n),
        .visible_x      (visible_x),
        .visible_y      (visible_y),
        .pixel_state    (pixel_state),
        .underrun       (underrun),
        .mem            (mem_bus.master)
    );

    always #40 clk_core_12288 = ~clk_core_12288;

    // Memory model: ack after ack_lat negedges of a held request, data = addr.
    int unsigned ack_lat = 1;
    int unsigned lat_cnt = 0;
    always @(negedge clk_core_12288) begin
        if (!mem_bus.mem_rd_req) begin
            mem_bus.mem_rd_ack = 1'b0;
            lat_cnt = 0;
        end else begin
            lat_cnt++;
            if (lat_cnt >= ack_lat) begin
                mem_bus.mem_rd_ack  = 1'b1;
                mem_bus.mem_rd_data = {3'b000, mem_bus.mem_rd_addr};
                lat_cnt = 0;
            end else begin
                mem_bus.mem_rd_ack = 1'b0;
            end
        end
    end

    int          checks = 0;
    int          errors = 0;
    logic [12:0] exp_q[$];
    int unsigned acks_seen = 0;

    initial begin
        #2000000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    // Advance one cycle; every ack taken at this edge is scored in order.
    task automatic tick();
        logic [12:0] ea;
        @(posedge clk_core_12288);
        #1;
        if (reset_n && mem_bus.mem_rd_ack) begin
            acks_seen++;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected addr=%0d required=none", mem_bus.mem_rd_data);
            end else begin
                ea = exp_q.pop_front();
                if (mem_bus.mem_rd_data !== {3'b000, ea}) begin
                    errors++;
                    $display("FAIL sb_addr addr=%0d required=%0d", mem_bus.mem_rd_data, ea);
                end
            end
        end
    endtask

    function automatic logic exp_pixel(input int unsigned line, input int unsigned x);
        logic [12:0] a;
        logic [15:0] d;
        a = 13'(line * 20 + x / 16);
        d = {3'b000, a};
        return d[x % 16];
    endfunction

    task automatic check_row(input int unsigned y, input int unsigned line, input string tag);
        int unsigned xs[12] = '{0, 1, 15, 16, 31, 100, 159, 200, 255, 304, 318, 319};
        logic e;
        visible_y = 10'(y);
        foreach (xs[i]) begin
            visible_x = 10'(xs[i]);
            #1;
            e = exp_pixel(line, xs[i]);
            checks++;
            if (pixel_state !== e) begin
                errors++;
                $display("FAIL %s x=%0d y=%0d pixel=%b required=%b", tag, xs[i], y, pixel_state, e);
            end
        end
        visible_x = 10'd500;
    endtask

    task automatic start_fetch(input int unsigned trig_y);
        int unsigned ny;
        ny = (trig_y + 1) % 1024;
        if (ny < 288) begin
            for (int unsigned w = 0; w < 20; w++) exp_q.push_back(13'(ny * 20 + w));
        end
        visible_y = 10'(trig_y);
        visible_x = 10'd320;
        tick();
        visible_x = 10'd500;
    endtask

    task automatic wait_fetch(input int unsigned budget, input string tag);
        int unsigned n = 0;
        while ((mem_bus.mem_rd_req || exp_q.size() != 0) && n < budget) begin
            tick();
            n++;
        end
        checks++;
        if (mem_bus.mem_rd_req || exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s_timeout req=%b pending=%0d required=0/0", tag, mem_bus.mem_rd_req, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic deadline();
        visible_x = 10'd1023;
        tick();
        visible_x = 10'd500;
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if (mem_bus.mem_rd_req !== 1'b0) begin errors++; $display("FAIL rst_req req=%b required=0", mem_bus.mem_rd_req); end
        checks++;
        if (mem_bus.mem_rd_addr !== 13'd0) begin errors++; $display("FAIL rst_addr addr=%0d required=0", mem_bus.mem_rd_addr); end
        checks++;
        if (underrun !== 1'b0) begin errors++; $display("FAIL rst_underrun underrun=%b required=0", underrun); end
        checks++;
        if (pixel_state !== 1'b0) begin errors++; $display("FAIL rst_pixel pixel=%b required=0", pixel_state); end
        tick();
        tick();
        reset_n = 1'b1;
        tick();
    endtask

    task automatic test_frame();
        int unsigned trig[6] = '{1023, 0, 1, 4, 142, 286};
        int unsigned ny;
        int unsigned prev = 0;
        ack_lat = 1;
        foreach (trig[i]) begin
            ny = (trig[i] + 1) % 1024;
            start_fetch(trig[i]);
            wait_fetch(40, "frame");
            if (i > 0) check_row(ny, prev, "pre_swap");
            deadline();
            check_row(ny, ny, "frame_row");
            prev = ny;
        end
        checks++;
        if (underrun !== 1'b0) begin errors++; $display("FAIL frame_underrun underrun=%b required=0", underrun); end
    endtask

    task automatic test_no_fetch();
        logic seen = 1'b0;
        visible_y = 10'd287;
        visible_x = 10'd320;
        tick();
        visible_x = 10'd500;
        for (int k = 0; k < 30; k++) begin
            tick();
            if (mem_bus.mem_rd_req) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0) begin errors++; $display("FAIL nofetch_req seen=%b required=0", seen); end
        deadline();
        check_row(287, 287, "idle_noswap");
    endtask

    task automatic test_underrun();
        ack_lat = 5;
        start_fetch(9);
        repeat (20) tick();
        checks++;
        if (underrun !== 1'b0) begin errors++; $display("FAIL ur_early underrun=%b required=0", underrun); end
        deadline();
        checks++;
        if (underrun !== 1'b1) begin errors++; $display("FAIL ur_flag underrun=%b required=1", underrun); end
        checks++;
        if (mem_bus.mem_rd_req !== 1'b1) begin errors++; $display("FAIL ur_req_held req=%b required=1", mem_bus.mem_rd_req); end
        check_row(10, 287, "ur_stale");
        wait_fetch(150, "ur_drain");
        checks++;
        if (dut.state !== ST_IDLE) begin errors++; $display("FAIL ur_state state=%0d required=%0d", dut.state, ST_IDLE); end
        check_row(10, 287, "ur_stale_after");
    endtask

    task automatic test_mid_reset();
        int unsigned base;
        int unsigned n = 0;
        ack_lat = 1;
        start_fetch(49);
        base = acks_seen;
        while ((acks_seen - base) < 7 && n < 50) begin
            tick();
            n++;
        end
        checks++;
        if ((acks_seen - base) != 7) begin errors++; $display("FAIL mr_acks acks=%0d required=7", acks_seen - base); end
        reset_n = 1'b0;
        #1;
        checks++;
        if (mem_bus.mem_rd_req !== 1'b0) begin errors++; $display("FAIL mr_req req=%b required=0", mem_bus.mem_rd_req); end
        checks++;
        if (underrun !== 1'b0) begin errors++; $display("FAIL mr_underrun underrun=%b required=0", underrun); end
        checks++;
        if (dut.disp_bank !== 1'b0) begin errors++; $display("FAIL mr_bank bank=%b required=0", dut.disp_bank); end
        exp_q.delete();
        repeat (3) tick();
        reset_n = 1'b1;
        tick();
        start_fetch(49);
        wait_fetch(40, "mr_restart");
        deadline();
        check_row(50, 50, "mr_row");
        checks++;
        if (dut.disp_bank !== 1'b1) begin errors++; $display("FAIL mr_swap bank=%b required=1", dut.disp_bank); end
    endtask

    task automatic test_busy_trigger();
        ack_lat = 3;
        start_fetch(59);
        repeat (10) tick();
        checks++;
        if (underrun !== 1'b0) begin errors++; $display("FAIL busy_early underrun=%b required=0", underrun); end
        visible_y = 10'd69;
        visible_x = 10'd320;
        tick();
        visible_x = 10'd500;
        checks++;
        if (underrun !== 1'b1) begin errors++; $display("FAIL busy_flag underrun=%b required=1", underrun); end
        wait_fetch(100, "busy");
        deadline();
        check_row(60, 60, "busy_row");
    endtask

    task automatic test_out_of_area();
        int unsigned cx[5] = '{4, 5, 10, 330, 600};
        int unsigned cy[5] = '{300, 288, 1023, 60, 60};
        foreach (cx[i]) begin
            visible_x = 10'(cx[i]);
            visible_y = 10'(cy[i]);
            #1;
            checks++;
            if (pixel_state !== 1'b0) begin
                errors++;
                $display("FAIL blank x=%0d y=%0d pixel=%b required=0", cx[i], cy[i], pixel_state);
            end
        end
        visible_x = 10'd500;
    endtask

    initial begin
        test_reset();
        test_frame();
        test_no_fetch();
        test_underrun();
        test_mid_reset();
        test_busy_trigger();
        test_out_of_area();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fb_line_fetcher.md
FB_LINE_FETCHER -- requirements
Module: fb_line_fetcher

Interface
REQ-001 SHALL have parameter FB_BASE, default 13'd0, word address of framebuffer line 0.
REQ-002 SHALL have parameter LINE_WORDS, default 20, 16-bit words per line (320 px, 1 bpp).
REQ-003 SHALL have parameter ACTIVE_LINES, default 288, number of displayed lines.
REQ-004 clk_core_12288  input  1  pixel clock; all logic on rising edge.
REQ-005 reset_n  input  1  asynchronous, active-low reset.
REQ-006 visible_x  input  10  display-controller column (x_count-10, unsigned wrap).
REQ-007 visible_y  input  10  display-controller row (y_count-10, unsigned wrap).
REQ-008 pixel_state  output  1  pixel bit for the current (visible_x, visible_y); 1 = lit.
REQ-009 mem_rd_req  output  1  read request to framebuffer memory.
REQ-010 mem_rd_addr  output  13  word address; stable while mem_rd_req high.
REQ-011 mem_rd_ack  input  1  one-cycle acknowledge; mem_rd_data valid in the same cycle.
REQ-012 mem_rd_data  input  16  read word; bit n = pixel 16*word+n.
REQ-013 underrun  output  1  sticky flag: a line fetch missed its deadline.

Function
REQ-014 SHALL hold two line banks of LINE_WORDS x 16 bits: display bank (disp_bank) and fill bank (~disp_bank).
REQ-015 pixel_state SHALL be combinational: bank[disp_bank][visible_x[8:4]][visible_x[3:0]] when visible_x<320 and visible_y<ACTIVE_LINES, else 0 (zero added latency).
REQ-016 Trigger SHALL occur on the cycle visible_x==320; next_y = visible_y+1 (10-bit wrap; 1023 -> 0).
REQ-017 On trigger with next_y<ACTIVE_LINES and FSM in IDLE: latch line_base = FB_BASE + next_y*LINE_WORDS, clear word counter, enter REQ.
REQ-018 On trigger with next_y>=ACTIVE_LINES: no action.
REQ-019 On trigger while FSM not IDLE: set underrun; trigger ignored.
REQ-020 FSM states: IDLE, REQ, DONE. IDLE->REQ on trigger (REQ-017).
REQ-021 In REQ: mem_rd_req=1, mem_rd_addr=line_base+word; on mem_rd_ack write mem_rd_data to fill bank[word]; if word==LINE_WORDS-1 go DONE, else word+1 and remain in REQ (req stays high, next address next cycle).
REQ-022 mem_rd_req SHALL never deassert before ack for the current address.
REQ-023 Swap deadline SHALL be the cycle visible_x==1023 (one cycle before column 0).
REQ-024 At deadline in DONE: toggle disp_bank, go IDLE.
REQ-025 At deadline in REQ: set underrun, set abort flag, no swap; remaining words SHALL still be requested/acked but not written; go IDLE after the outstanding ack completes (abort cleared).
REQ-026 At deadline in IDLE: no action.
REQ-027 Address arithmetic 13-bit, wraps modulo 2^13; next_y*LINE_WORDS computed as shift-add, no multiplier.
REQ-028 underrun cleared only by reset.

Reset
REQ-029 On reset_n low, asynchronously: FSM=IDLE, mem_rd_req=0, mem_rd_addr=0, word=0, line_base=0, disp_bank=0, abort=0, underrun=0.
REQ-030 Bank contents SHALL NOT be reset (RAM-inferable); pixel_state undefined-but-stable until first swap, 0 outside active area.
REQ-031 Reset mid-fetch SHALL drop mem_rd_req immediately; memory side must tolerate abandoned request.

Structure
REQ-032 Shared package SHALL hold H_ACTIVE=320, ACTIVE_LINES=288, LINE_WORDS=20, FSM state encoding, address width 13.
REQ-033 One sub-module fb_line_bank (LINE_WORDS x 16, 1 write port, 1 async read port) instantiated twice.

Verification
REQ-034 Memory model acks 1 cycle after req, data=addr; run frame -> line y fetches addrs 20y..20y+19, pixel_state at (x,y) equals bit x%16 of word 20y+x/16, underrun=0.
REQ-035 visible_y=1023, visible_x=320 trigger -> addresses 0..19 fetched, swap at visible_x==1023, row 0 displayed correctly.
REQ-036 Ack latency 5 cycles -> fetch incomplete at deadline: underrun=1, no swap, stale line shown, req held until ack, FSM IDLE after.
REQ-037 visible_y=287 trigger (next_y=288) -> mem_rd_req stays 0 through line.
REQ-038 reset_n low during word 7 -> mem_rd_req=0 same cycle, underrun=0, disp_bank=0; next trigger restarts at word 0.
REQ-039 visible_x=330 or visible_y=300 -> pixel_state=0 regardless of bank contents.
